// File: rtl/chan_scan_pkg.sv
// Shared types and sizing for the channel scan sequencer.
package chan_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/next_chan_find.sv
// Combinational circular search for the next enabled channel after cur_i.
// Seeding cur_i with NUM_CH-1 yields the lowest enabled channel.
module next_chan_find
    import chan_scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              found_o,
    output logic              wraps_o
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        idx     = '0;
        // Walk from farthest to nearest so the closest hit is written last;
        // i == NUM_CH lands back on cur_i itself (single-channel case).
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = cur_i + i[SEL_W-1:0];
            if (mask_i[idx]) begin
                next_o  = idx;
                found_o = 1'b1;
            end
        end
        wraps_o = found_o && (next_o <= cur_i);
    end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: steps through enabled channels 0-7, holding each for dwell+1 cycles.
// Channel skipping via mask only when CHAN_SCAN_SKIP_EN is defined; otherwise all channels are visited.
module chan_scan_seq
    import chan_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               wrap,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;

    logic [NUM_CH-1:0]  eff_mask;
    logic [SEL_W-1:0]   seed;
    logic [SEL_W-1:0]   nxt;
    logic               nxt_found;
    logic               nxt_wraps;

`ifdef CHAN_SCAN_SKIP_EN
    assign eff_mask = mask;
`else
    // Port stays connected; the OR folds to all-ones.
    assign eff_mask = mask | {NUM_CH{1'b1}};
`endif

    assign seed = (state_q == IDLE) ? SEL_W'(NUM_CH - 1) : sel_q;

    next_chan_find u_find (
        .cur_i   (seed),
        .mask_i  (eff_mask),
        .next_o  (nxt),
        .found_o (nxt_found),
        .wraps_o (nxt_wraps)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && nxt_found) begin
                    state_d = RUN;
                    sel_d   = nxt;
                    cnt_d   = dwell;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (nxt_found) begin
                    sel_d  = nxt;
                    cnt_d  = dwell;
                    wrap_d = nxt_wraps;
                end else begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq with a cycle reference model feeding an expected-output queue.
module tb_chan_scan_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid;
    logic       wrap;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic       vld;
        logic       wrap;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit m_run;
    int m_sel;
    int m_cnt;
    bit m_wrap;
    int wrap_seen;

    chan_scan_seq #(.DWELL_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .mask      (mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] eff_mask();
`ifdef CHAN_SCAN_SKIP_EN
        return mask;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic go_idle();
        m_run = 0; m_sel = 0; m_cnt = 0; m_wrap = 0;
    endtask

    task automatic model_next();
        logic [7:0] em;
        int         n;
        em = eff_mask();
        m_wrap = 0;
        if (reset) begin
            go_idle();
        end else if (!m_run) begin
            if (start && em != 8'h00) begin
                n = -1;
                for (int c = 7; c >= 0; c--) if (em[c]) n = c;
                m_run = 1; m_sel = n; m_cnt = int'(dwell);
            end
        end else if (stop) begin
            go_idle();
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else begin
            n = -1;
            for (int j = 1; j <= 8 && n < 0; j++)
                if (em[(m_sel + j) % 8]) n = (m_sel + j) % 8;
            if (n < 0) begin
                go_idle();
            end else begin
                m_wrap = (n <= m_sel);
                m_sel  = n;
                m_cnt  = int'(dwell);
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checks++;
        assert (sel === e.sel) else begin
            failures++; $error("FAIL sel obs=%0d exp=%0d t=%0t", sel, e.sel, $time);
        end
        checks++;
        assert (sel_valid === e.vld) else begin
            failures++; $error("FAIL sel_valid obs=%0b exp=%0b t=%0t", sel_valid, e.vld, $time);
        end
        checks++;
        assert (wrap === e.wrap) else begin
            failures++; $error("FAIL wrap obs=%0b exp=%0b t=%0t", wrap, e.wrap, $time);
        end
        checks++;
        assert (busy === e.busy) else begin
            failures++; $error("FAIL busy obs=%0b exp=%0b t=%0t", busy, e.busy, $time);
        end
        if (wrap === 1'b1) wrap_seen++;
    endtask

    task automatic step();
        exp_t e;
        model_next();
        e.sel  = 3'(m_sel);
        e.vld  = m_run;
        e.wrap = m_wrap;
        e.busy = m_run;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        assert (0) else begin
            failures++; $error("FAIL %s bound expired", tag);
        end
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; stop = 1'b0; dwell = 4'd0; mask = 8'h00;
        steps(2);
        reset = 1'b0;
        steps(2);

        // Full sweep, dwell 2: exactly one wrap on return to 0
        mask = 8'hFF; dwell = 4'd2; start = 1'b1;
        wrap_seen = 0;
        step();
        start = 1'b0;
        steps(25);
        checks++;
        assert (wrap_seen == 1) else begin
            failures++; $error("FAIL sweep_wrap_count obs=%0d exp=1", wrap_seen);
        end
        stop = 1'b1; step(); stop = 1'b0; step();

        // Sparse mask, dwell 0
        mask = 8'b1010_0100; dwell = 4'd0; start = 1'b1; step(); start = 1'b0;
        steps(8);
        stop = 1'b1; step(); stop = 1'b0;

        // Single channel, dwell 1; start in RUN ignored
        mask = 8'b0001_0000; dwell = 4'd1; start = 1'b1; step();
        steps(3);
        start = 1'b0;
        steps(4);
        stop = 1'b1; step(); stop = 1'b0;

        // Stop coinciding with an advance from channel 3
        mask = 8'hFF; dwell = 4'd3; start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (!(m_run && m_sel == 3 && m_cnt == 0) && guard < 60) begin step(); guard++; end
        if (guard >= 60) bound_fail("reach_ch3");
        stop = 1'b1; step(); stop = 1'b0;
        steps(2);

        // Mask cleared mid-dwell on channel 6, dwell sampled at each load
        mask = 8'hFF; dwell = 4'd3; start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (!(m_run && m_sel == 6 && m_cnt == 2) && guard < 60) begin step(); guard++; end
        if (guard >= 60) bound_fail("reach_ch6");
        mask = 8'h00; dwell = 4'd1;
        steps(6);
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        steps(2);

        // Reset mid-scan at channel 5, then restart from lowest enabled
        mask = 8'hFF; dwell = 4'd1; start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (!(m_run && m_sel == 5) && guard < 60) begin step(); guard++; end
        if (guard >= 60) bound_fail("reach_ch5");
        reset = 1'b1; step(); reset = 1'b0;
        mask = 8'b0110_0000; dwell = 4'd0; start = 1'b1; step(); start = 1'b0;
        steps(4);

        // Stop alone in IDLE ignored; start+stop together in IDLE starts
        reset = 1'b1; step(); reset = 1'b0;
        stop = 1'b1; step();
        start = 1'b1; mask = 8'b1000_0001; dwell = 4'd0; step();
        start = 1'b0; stop = 1'b0;
        steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
